// File: rtl/terminal_text_controller.sv
// Write-port sequencer for the terminal character buffer: cursor tracking, control
// codes, scrolling by rotating a row offset, and one-write-per-cycle row/screen blanking.
//
// state     | meaning
// IDLE      | accepting one code per cycle from the front end
// CLEAR_ROW | blanking the physical row that just became the bottom row
// CLEAR_ALL | blanking the whole buffer (after reset or form feed)
module terminal_text_controller #(
  parameter int         COLS  = 64,
  parameter int         ROWS  = 40,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_n_in,
  input  logic                          char_valid_in,
  input  logic [7:0]                    char_in,
  output logic                          char_ready_out,
  output logic                          wr_en_out,
  output logic [$clog2(ROWS*COLS)-1:0]  wr_addr_out,
  output logic [7:0]                    wr_data_out,
  output logic [$clog2(ROWS)-1:0]       cursor_row_out,
  output logic [$clog2(COLS)-1:0]       cursor_col_out,
  output logic [$clog2(ROWS)-1:0]       scroll_offset_out
);

  localparam int N   = ROWS * COLS;
  localparam int AW  = $clog2(N);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int RW1 = RW + 1;

  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [AW-1:0] ROW_END   = AW'(COLS - 1);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [RW:0]   ROWS_W    = RW1'(ROWS);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   clr_row_q, clr_row_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   off_q, off_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [RW-1:0]   cur_phys;
  logic            accept;
  logic            advance;

  // Both operands are below ROWS, so one conditional subtract replaces the modulo.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] r, input logic [RW-1:0] o);
    logic [RW:0] sum;
    sum = {1'b0, r} + {1'b0, o};
    return (sum >= ROWS_W) ? RW'(sum - ROWS_W) : RW'(sum);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] prow, input logic [CW-1:0] col);
    return AW'(prow) * COLS_A + AW'(col);
  endfunction

  assign accept   = char_valid_in && (state_q == IDLE);
  assign cur_phys = phys_row(row_q, off_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_row_d = clr_row_q;
    row_d     = row_q;
    col_d     = col_q;
    off_d     = off_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    advance   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_of(cur_phys, col_q);
            wr_data_d = char_in;
            if (col_q < LAST_COL) begin
              col_d = col_q + CW'(1);
            end else begin
              col_d   = '0;
              advance = 1'b1;
            end
          end else if (char_in == 8'h0A) begin
            col_d   = '0;
            advance = 1'b1;
          end else if (char_in == 8'h08) begin
            if (col_q != '0) begin
              col_d     = col_q - CW'(1);
              wr_en_d   = 1'b1;
              wr_addr_d = addr_of(cur_phys, col_q - CW'(1));
              wr_data_d = BLANK;
            end else if (row_q != '0) begin
              row_d     = row_q - RW'(1);
              col_d     = LAST_COL;
              wr_en_d   = 1'b1;
              wr_addr_d = addr_of(phys_row(row_q - RW'(1), off_q), LAST_COL);
              wr_data_d = BLANK;
            end
          end else if (char_in == 8'h0C) begin
            row_d   = '0;
            col_d   = '0;
            off_d   = '0;
            cnt_d   = '0;
            state_d = CLEAR_ALL;
          end

          // At the bottom row the old top physical row becomes the new bottom row.
          if (advance) begin
            if (row_q < LAST_ROW) begin
              row_d = row_q + RW'(1);
            end else begin
              off_d     = (off_q == LAST_ROW) ? '0 : off_q + RW'(1);
              clr_row_d = off_q;
              cnt_d     = '0;
              state_d   = CLEAR_ROW;
            end
          end
        end
      end

      CLEAR_ROW: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_of(clr_row_q, cnt_q[CW-1:0]);
        wr_data_d = BLANK;
        if (cnt_q == ROW_END) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      CLEAR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = BLANK;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      default: begin
        state_d = CLEAR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= CLEAR_ALL;
      cnt_q     <= '0;
      clr_row_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      off_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_row_q <= clr_row_d;
      row_q     <= row_d;
      col_q     <= col_d;
      off_q     <= off_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign char_ready_out    = (state_q == IDLE);
  assign wr_en_out         = wr_en_q;
  assign wr_addr_out       = wr_addr_q;
  assign wr_data_out       = wr_data_q;
  assign cursor_row_out    = row_q;
  assign cursor_col_out    = col_q;
  assign scroll_offset_out = off_q;

endmodule

// File: tb/tb_terminal_text_controller.sv
// Bench for terminal_text_controller at COLS=4, ROWS=3: directed vectors, timing
// sequences and random codes checked against a screen-level reference model.
module tb_terminal_text_controller;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam logic [7:0] BLANK = 8'h20;

  logic       clk;
  logic       rst_n;
  logic       char_valid_in;
  logic [7:0] char_in;
  logic       char_ready_out;
  logic       wr_en_out;
  logic [3:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic [1:0] cursor_row_out;
  logic [1:0] cursor_col_out;
  logic [1:0] scroll_offset_out;

  terminal_text_controller #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .pixel_clk_in      (clk),
    .rst_n_in          (rst_n),
    .char_valid_in     (char_valid_in),
    .char_in           (char_in),
    .char_ready_out    (char_ready_out),
    .wr_en_out         (wr_en_out),
    .wr_addr_out       (wr_addr_out),
    .wr_data_out       (wr_data_out),
    .cursor_row_out    (cursor_row_out),
    .cursor_col_out    (cursor_col_out),
    .scroll_offset_out (scroll_offset_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: logical cursor, offset, and the ordered list of writes it implies.
  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  m_row, m_col, m_off;

  function automatic void push(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endfunction

  function automatic void model_newline();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < COLS; c++) push(m_off * COLS + c, BLANK);
      m_off = (m_off + 1) % ROWS;
    end
  endfunction

  function automatic void model_accept(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push(((m_row + m_off) % ROWS) * COLS + m_col, c);
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0;
        model_newline();
      end
    end else if (c == 8'h0A) begin
      m_col = 0;
      model_newline();
    end else if (c == 8'h08) begin
      if (m_col > 0 || m_row > 0) begin
        if (m_col > 0) m_col--;
        else begin
          m_row--;
          m_col = COLS - 1;
        end
        push(((m_row + m_off) % ROWS) * COLS + m_col, BLANK);
      end
    end else if (c == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      m_off = 0;
      for (int a = 0; a < ROWS * COLS; a++) push(a, BLANK);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && wr_en_out) begin
      chk("write_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mon_wr_addr", wr_addr_out, e.addr);
        chk("mon_wr_data", wr_data_out, e.data);
      end
    end
  end

  // Starts and ends on a falling edge; returns in the cycle after the accept edge.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (!char_ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", char_ready_out, 1);
    char_valid_in = 1'b1;
    char_in       = c;
    model_accept(c);
    @(negedge clk);
    char_valid_in = 1'b0;
  endtask

  task automatic chk_cursor(input string nm);
    chk({nm, "_row"}, cursor_row_out, m_row);
    chk({nm, "_col"}, cursor_col_out, m_col);
    chk({nm, "_off"}, scroll_offset_out, m_off);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         wr;
    int         addr;
    int         data;
    int         row;
    int         col;
    int         off;
  } tv_t;
  tv_t tv[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{8'h41, 1, 0, 8'h41, 0, 1, 0};
    tv[1]  = '{8'h42, 1, 1, 8'h42, 0, 2, 0};
    tv[2]  = '{8'h07, 0, 0, 0,     0, 2, 0};
    tv[3]  = '{8'h0A, 0, 0, 0,     1, 0, 0};
    tv[4]  = '{8'h08, 1, 3, 8'h20, 0, 3, 0};
    tv[5]  = '{8'h43, 1, 3, 8'h43, 1, 0, 0};
    tv[6]  = '{8'h08, 1, 3, 8'h20, 0, 3, 0};
    tv[7]  = '{8'h08, 1, 2, 8'h20, 0, 2, 0};
    tv[8]  = '{8'h08, 1, 1, 8'h20, 0, 1, 0};
    tv[9]  = '{8'h08, 1, 0, 8'h20, 0, 0, 0};
    tv[10] = '{8'h08, 0, 0, 0,     0, 0, 0};

    rst_n = 1'b0;
    char_valid_in = 1'b0;
    char_in = 8'h00;
    m_row = 0; m_col = 0; m_off = 0;
    for (int a = 0; a < ROWS * COLS; a++) push(a, BLANK);

    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en_out, 0);
    chk("rst_wr_addr", wr_addr_out, 0);
    chk("rst_ready", char_ready_out, 0);
    chk("rst_cursor", {cursor_row_out, cursor_col_out, scroll_offset_out}, 0);

    rst_n = 1'b1;
    for (int k = 0; k < ROWS * COLS; k++) begin
      @(negedge clk);
      chk("init_clr_en", wr_en_out, 1);
      chk("init_clr_addr", wr_addr_out, k);
      chk("init_clr_ready", char_ready_out, (k == ROWS * COLS - 1));
    end
    @(negedge clk);
    chk("init_idle_wr_en", wr_en_out, 0);
    chk_cursor("init_cursor");

    for (int i = 0; i < 11; i++) begin
      send(tv[i].code);
      chk("tv_wr_en", wr_en_out, tv[i].wr);
      if (tv[i].wr) begin
        chk("tv_wr_addr", wr_addr_out, tv[i].addr);
        chk("tv_wr_data", wr_data_out, tv[i].data);
      end
      chk("tv_row", cursor_row_out, tv[i].row);
      chk("tv_col", cursor_col_out, tv[i].col);
      chk("tv_off", scroll_offset_out, tv[i].off);
    end

    // "ABCDE" with valid held: one accept and one write per cycle.
    char_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      char_in = 8'h41 + 8'(i);
      chk("stream_ready", char_ready_out, 1);
      model_accept(char_in);
      @(negedge clk);
      chk("stream_wr_en", wr_en_out, 1);
      chk("stream_wr_addr", wr_addr_out, i);
      chk("stream_wr_data", wr_data_out, 32'(8'h41 + i));
    end
    char_valid_in = 1'b0;
    chk("stream_row", cursor_row_out, 1);
    chk("stream_col", cursor_col_out, 1);

    for (int i = 0; i < 6; i++) send(8'($urandom_range(32, 126)));
    chk("fill_row", cursor_row_out, 2);
    chk("fill_col", cursor_col_out, 3);

    send(8'h5A);
    chk("scroll_z_en", wr_en_out, 1);
    chk("scroll_z_addr", wr_addr_out, 11);
    chk("scroll_z_data", wr_data_out, 8'h5A);
    chk("scroll_off", scroll_offset_out, 1);
    chk("scroll_row", cursor_row_out, 2);
    chk("scroll_col", cursor_col_out, 0);
    chk("scroll_ready_e0", char_ready_out, 0);
    for (int k = 0; k < COLS; k++) begin
      @(negedge clk);
      chk("scroll_clr_en", wr_en_out, 1);
      chk("scroll_clr_addr", wr_addr_out, k);
      chk("scroll_clr_data", wr_data_out, 8'h20);
      chk("scroll_clr_ready", char_ready_out, (k == COLS - 1));
    end
    @(negedge clk);
    chk("scroll_done_wr_en", wr_en_out, 0);

    send(8'h51);
    chk("offset_q_en", wr_en_out, 1);
    chk("offset_q_addr", wr_addr_out, 0);
    chk("offset_q_data", wr_data_out, 8'h51);
    chk_cursor("offset_q");

    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(32, 126));
      else if (r < 80) c = 8'h0A;
      else if (r < 92) c = 8'h08;
      else if (r < 94) c = 8'h0C;
      else             c = 8'(128 + $urandom_range(0, 127));
      send(c);
      chk_cursor("rand");
    end

    send(8'h0A);
    send(8'h61);
    send(8'h0C);
    chk("ff_ready", char_ready_out, 0);
    chk_cursor("ff_cursor");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ff_clr_addr", wr_addr_out, k);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en_out, 0);
    chk("midrst_ready", char_ready_out, 0);
    chk("midrst_outs", {wr_addr_out, wr_data_out, cursor_row_out, cursor_col_out, scroll_offset_out}, 0);
    exp_q.delete();
    m_row = 0; m_col = 0; m_off = 0;
    for (int a = 0; a < ROWS * COLS; a++) push(a, BLANK);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < ROWS * COLS; k++) begin
      @(negedge clk);
      chk("reclr_en", wr_en_out, 1);
      chk("reclr_addr", wr_addr_out, k);
      chk("reclr_ready", char_ready_out, (k == ROWS * COLS - 1));
    end
    chk_cursor("reclr_cursor");

    for (int n = 0; n < 100 && !char_ready_out; n++) @(negedge clk);
    @(negedge clk);
    chk("final_idle", char_ready_out, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
